// File: rtl/alarm_seq.sv
// ---------------------------------------------------------------------------
// alarm_seq : alarm ring / snooze sequencer
//
// Watches the running time of day and, when it reaches the programmed alarm
// time at second zero (on a 1 Hz tick, alarm armed), starts a ring episode.
// A ring episode ends on a stop key, on an auto-stop timeout, or moves into
// a snooze period on a snooze key while snoozes remain. A snooze period
// returns to ringing after its timeout. Disarming the alarm always returns
// to idle.
//
// Ports
//   clk            system clock, all state on rising edge
//   rst_n          asynchronous active-low reset
//   tick_1hz       one-cycle pulse per second
//   cur_hour/min/sec  current time of day
//   alm_hour/min   alarm time
//   alarm_en       alarm armed (level)
//   key_stop       one-cycle stop key pulse
//   key_snooze     one-cycle snooze key pulse
//   alarm_ringing  high while ringing
//   buzzer         buzzer drive, 1 s on / 1 s off while ringing
//   snooze_active  high while snoozing
//   snooze_left    snoozes remaining for the current alarm event
//   state          FSM state: IDLE=00, RINGING=01, SNOOZE=10
//
// Handshake: there are no valid/ready channels; tick_1hz, key_stop and
// key_snooze are single-cycle event pulses sampled on the rising clock edge.
// Within one cycle the precedence is: alarm disarm, stop, snooze, timeout.
// ---------------------------------------------------------------------------
module alarm_seq #(
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300,
  parameter int MAX_SNOOZE = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  input  logic [4:0] alm_hour,
  input  logic [5:0] alm_min,
  input  logic       alarm_en,
  input  logic       key_stop,
  input  logic       key_snooze,
  output logic       alarm_ringing,
  output logic       buzzer,
  output logic       snooze_active,
  output logic [1:0] snooze_left,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RINGING = 2'b01,
    ST_SNOOZE  = 2'b10,
    ST_BAD     = 2'b11
  } state_t;

  localparam logic [8:0] RING_LIM   = 9'(RING_SEC);
  localparam logic [8:0] SNOOZE_LIM = 9'(SNOOZE_SEC);
  localparam logic [1:0] SNZ_INIT   = 2'(MAX_SNOOZE);
  localparam logic [8:0] SEC_MAX    = 9'h1FF;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [8:0] r_sec_cnt;
  logic [8:0] w_sec_cnt_nxt;
  logic [1:0] r_snooze_left;
  logic [1:0] w_snooze_left_nxt;

  logic       w_match;
  logic [8:0] w_sec_inc;

  // Alarm time hit: only at second zero on a tick, so a stopped alarm
  // cannot fire again within the same minute.
  assign w_match = alarm_en && tick_1hz &&
                   (cur_hour == alm_hour) &&
                   (cur_min  == alm_min)  &&
                   (cur_sec  == 6'd0);

  // Saturating seconds increment.
  assign w_sec_inc = (r_sec_cnt == SEC_MAX) ? r_sec_cnt : (r_sec_cnt + 9'd1);

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nxt       = r_state;
    w_sec_cnt_nxt     = r_sec_cnt;
    w_snooze_left_nxt = r_snooze_left;

    case (r_state)
      ST_IDLE: begin
        // Keys are deliberately ignored here; only a match leaves idle.
        if (w_match) begin
          w_state_nxt       = ST_RINGING;
          w_sec_cnt_nxt     = 9'd0;
          w_snooze_left_nxt = SNZ_INIT;
        end
      end

      ST_RINGING: begin
        if (!alarm_en || key_stop) begin
          w_state_nxt   = ST_IDLE;
          w_sec_cnt_nxt = 9'd0;
        end else if (key_snooze) begin
          // Out of snoozes: the snooze key behaves like stop.
          if (r_snooze_left != 2'd0) begin
            w_state_nxt       = ST_SNOOZE;
            w_snooze_left_nxt = r_snooze_left - 2'd1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
          w_sec_cnt_nxt = 9'd0;
        end else if (tick_1hz) begin
          if (w_sec_inc == RING_LIM) begin
            w_state_nxt   = ST_IDLE;
            w_sec_cnt_nxt = 9'd0;
          end else begin
            w_sec_cnt_nxt = w_sec_inc;
          end
        end
      end

      ST_SNOOZE: begin
        // The snooze key has no meaning while already snoozing.
        if (!alarm_en || key_stop) begin
          w_state_nxt   = ST_IDLE;
          w_sec_cnt_nxt = 9'd0;
        end else if (tick_1hz) begin
          if (w_sec_inc == SNOOZE_LIM) begin
            w_state_nxt   = ST_RINGING;
            w_sec_cnt_nxt = 9'd0;
          end else begin
            w_sec_cnt_nxt = w_sec_inc;
          end
        end
      end

      default: begin
        // Unused encoding: recover to idle on the next edge.
        w_state_nxt   = ST_IDLE;
        w_sec_cnt_nxt = 9'd0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_sec_cnt     <= 9'd0;
      r_snooze_left <= SNZ_INIT;
    end else begin
      r_state       <= w_state_nxt;
      r_sec_cnt     <= w_sec_cnt_nxt;
      r_snooze_left <= w_snooze_left_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs: pure decodes of registered state, so reset silences the
  // buzzer immediately and no input reaches an output combinationally.
  // The counter is zero on ring entry, so the buzzer starts in its on phase.
  // -------------------------------------------------------------------------
  assign alarm_ringing = (r_state == ST_RINGING);
  assign snooze_active = (r_state == ST_SNOOZE);
  assign buzzer        = alarm_ringing && !r_sec_cnt[0];
  assign snooze_left   = r_snooze_left;
  assign state         = r_state;

endmodule

// File: tb/tb_alarm_seq.sv
// ---------------------------------------------------------------------------
// tb_alarm_seq : directed bench for alarm_seq (default parameters,
// alarm set to 07:30).
// ---------------------------------------------------------------------------
module tb_alarm_seq;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_1hz = 1'b0;
  logic [4:0] cur_hour = 5'd7;
  logic [5:0] cur_min = 6'd0;
  logic [5:0] cur_sec = 6'd0;
  logic [4:0] alm_hour = 5'd7;
  logic [5:0] alm_min = 6'd30;
  logic       alarm_en = 1'b0;
  logic       key_stop = 1'b0;
  logic       key_snooze = 1'b0;
  logic       alarm_ringing;
  logic       buzzer;
  logic       snooze_active;
  logic [1:0] snooze_left;
  logic [1:0] state;

  always #5 clk = ~clk;

  alarm_seq dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .tick_1hz      (tick_1hz),
    .cur_hour      (cur_hour),
    .cur_min       (cur_min),
    .cur_sec       (cur_sec),
    .alm_hour      (alm_hour),
    .alm_min       (alm_min),
    .alarm_en      (alarm_en),
    .key_stop      (key_stop),
    .key_snooze    (key_snooze),
    .alarm_ringing (alarm_ringing),
    .buzzer        (buzzer),
    .snooze_active (snooze_active),
    .snooze_left   (snooze_left),
    .state         (state)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [4:0] exp_q[$];   // {state, snooze_left, buzzer}

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic [1:0] st,
                         input logic [1:0] left, input logic bz);
    chk({name, "_state"}, 9'(state), 9'(st));
    chk({name, "_left"},  9'(snooze_left), 9'(left));
    chk({name, "_buzz"},  9'(buzzer), 9'(bz));
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after a rising edge; outputs are sampled at
  // the same point, i.e. after the edge that consumed the previous inputs.
  task automatic drive(input logic t, input logic stp, input logic snz);
    tick_1hz   = t;
    key_stop   = stp;
    key_snooze = snz;
    @(posedge clk);
    #1;
    tick_1hz   = 1'b0;
    key_stop   = 1'b0;
    key_snooze = 1'b0;
  endtask

  task automatic set_time(input logic [5:0] m, input logic [5:0] s);
    cur_hour = 5'd7;
    cur_min  = m;
    cur_sec  = s;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       t;
    logic       stp;
    logic       snz;
    logic       en;
    logic [5:0] m;
    logic [5:0] s;
    logic [1:0] st;
    logic [1:0] left;
    logic       bz;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic t, input logic stp, input logic snz,
                              input logic en, input logic [5:0] m, input logic [5:0] s,
                              input logic [1:0] st, input logic [1:0] left, input logic bz);
    vec_t v;
    v.t = t; v.stp = stp; v.snz = snz; v.en = en; v.m = m; v.s = s;
    v.st = st; v.left = left; v.bz = bz;
    return v;
  endfunction

  initial begin
    //              t  stp snz en  min sec  state  left bz
    vecs[0]  = mk(1, 0, 0, 1, 29, 59, 2'b00, 2'd3, 0); // 07:29:59, no match
    vecs[1]  = mk(0, 0, 0, 1, 30, 0,  2'b00, 2'd3, 0); // right time, no tick
    vecs[2]  = mk(1, 0, 0, 0, 30, 0,  2'b00, 2'd3, 0); // disarmed
    vecs[3]  = mk(1, 1, 0, 1, 30, 0,  2'b01, 2'd3, 1); // match; stop ignored in idle
    vecs[4]  = mk(0, 0, 0, 1, 30, 0,  2'b01, 2'd3, 1); // still ringing, buzz on
    vecs[5]  = mk(1, 0, 0, 1, 30, 1,  2'b01, 2'd3, 0); // cnt 1 -> buzz off
    vecs[6]  = mk(1, 0, 0, 1, 30, 2,  2'b01, 2'd3, 1); // cnt 2 -> buzz on
    vecs[7]  = mk(1, 0, 0, 1, 30, 0,  2'b01, 2'd3, 0); // match ignored, cnt 3
    vecs[8]  = mk(0, 0, 1, 1, 30, 0,  2'b10, 2'd2, 0); // snooze
    vecs[9]  = mk(1, 0, 1, 1, 30, 1,  2'b10, 2'd2, 0); // snooze key ignored
    vecs[10] = mk(0, 1, 0, 1, 30, 1,  2'b00, 2'd2, 0); // stop from snooze
    vecs[11] = mk(1, 0, 0, 1, 30, 5,  2'b00, 2'd2, 0); // sec != 0, no match
    vecs[12] = mk(1, 0, 0, 1, 30, 0,  2'b01, 2'd3, 1); // match reloads snoozes
    vecs[13] = mk(1, 1, 1, 1, 30, 0,  2'b00, 2'd3, 0); // stop+snooze+tick: stop wins
    vecs[14] = mk(1, 0, 0, 1, 30, 0,  2'b01, 2'd3, 1); // ring again
    vecs[15] = mk(1, 0, 1, 1, 30, 1,  2'b10, 2'd2, 0); // snooze beats tick
    vecs[16] = mk(0, 0, 0, 0, 30, 1,  2'b00, 2'd2, 0); // disarm during snooze
  end

  // ---------------- test ----------------
  initial begin
    logic [4:0] e;

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 2'b00, 2'd3, 1'b0);
    chk("reset_ringing", 9'(alarm_ringing), 9'd0);
    chk("reset_snz_act", 9'(snooze_active), 9'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table-driven vectors
    for (int i = 0; i < NV; i++) begin
      alarm_en = vecs[i].en;
      set_time(vecs[i].m, vecs[i].s);
      exp_q.push_back({vecs[i].st, vecs[i].left, vecs[i].bz});
      drive(vecs[i].t, vecs[i].stp, vecs[i].snz);
      e = exp_q.pop_front();
      chk_out($sformatf("vec%0d", i), e[4:3], e[2:1], e[0]);
    end

    // Sequence A: ring auto-stops after 60 ticks
    alarm_en = 1'b1;
    set_time(6'd29, 6'd59);
    drive(1, 0, 0);
    set_time(6'd30, 6'd0);
    drive(1, 0, 0);
    chk_out("a_entry", 2'b01, 2'd3, 1'b1);
    for (int i = 1; i <= 59; i++) begin
      set_time(6'd30, 6'(i));
      drive(1, 0, 0);
      if (i == 1) chk_out("a_tick1", 2'b01, 2'd3, 1'b0);
      if (i == 2) chk_out("a_tick2", 2'b01, 2'd3, 1'b1);
      drive(0, 0, 0);
    end
    chk_out("a_tick59", 2'b01, 2'd3, 1'b0);
    set_time(6'd31, 6'd0);
    drive(1, 0, 0);
    chk_out("a_tick60", 2'b00, 2'd3, 1'b0);
    chk("a_ringing", 9'(alarm_ringing), 9'd0);

    // Sequence B: three snoozes with 300 s periods, then a fourth press stops
    set_time(6'd30, 6'd0);
    drive(1, 0, 0);
    chk_out("b_entry", 2'b01, 2'd3, 1'b1);
    set_time(6'd30, 6'd1);
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 1);
      chk_out($sformatf("b_snz%0d", k), 2'b10, 2'(2 - k), 1'b0);
      chk($sformatf("b_snzact%0d", k), 9'(snooze_active), 9'd1);
      for (int i = 1; i <= 300; i++) begin
        drive(1, 0, 0);
        if (i == 299) chk($sformatf("b_t299_%0d", k), 9'(state), 9'd2);
        drive(0, 0, 0);
      end
      chk_out($sformatf("b_wake%0d", k), 2'b01, 2'(2 - k), 1'b1);
    end
    drive(0, 0, 1);
    chk_out("b_snz_exhaust", 2'b00, 2'd0, 1'b0);

    // Sequence C: stop at 07:30:05, rest of the minute must not re-ring
    set_time(6'd30, 6'd0);
    drive(1, 0, 0);
    chk_out("c_entry", 2'b01, 2'd3, 1'b1);
    for (int s = 1; s <= 5; s++) begin
      set_time(6'd30, 6'(s));
      drive(1, 0, 0);
    end
    chk_out("c_sec5", 2'b01, 2'd3, 1'b0);
    drive(0, 1, 0);
    chk_out("c_stop", 2'b00, 2'd3, 1'b0);
    for (int s = 6; s <= 59; s++) begin
      set_time(6'd30, 6'(s));
      drive(1, 0, 0);
    end
    set_time(6'd31, 6'd0);
    drive(1, 0, 0);
    chk_out("c_no_retrig", 2'b00, 2'd3, 1'b0);

    // Sequence D: asynchronous reset mid-snooze and mid-ring
    set_time(6'd30, 6'd0);
    drive(1, 0, 0);
    drive(0, 0, 1);
    chk_out("d_snooze", 2'b10, 2'd2, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("d_rst_snz", 2'b00, 2'd3, 1'b0);
    chk("d_rst_snzact", 9'(snooze_active), 9'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(1, 0, 0);
    chk_out("d_ring", 2'b01, 2'd3, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("d_rst_ring", 2'b00, 2'd3, 1'b0);
    chk("d_rst_ringing", 9'(alarm_ringing), 9'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(1, 0, 0);
    chk_out("d_after_rst", 2'b01, 2'd3, 1'b1);

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alarm_seq.md
ALARM_SEQ -- requirements
Module: alarm_seq

Interface
REQ-001 Parameter RING_SEC, default 60, maximum seconds one ring episode lasts before auto-stop.
REQ-002 Parameter SNOOZE_SEC, default 300, seconds of silence after a snooze press.
REQ-003 Parameter MAX_SNOOZE, default 3, snoozes permitted per alarm event.
REQ-004 Port list (name, direction, width, meaning), one port per line:
- clk, input, 1, system clock; one clock domain, all state on posedge clk.
- rst_n, input, 1, reset, asynchronous, active-low.
- tick_1hz, input, 1, one-cycle pulse once per second.
- cur_hour, input, 5, current hour, 0-23.
- cur_min, input, 6, current minute, 0-59.
- cur_sec, input, 6, current second, 0-59.
- alm_hour, input, 5, alarm hour, 0-23.
- alm_min, input, 6, alarm minute, 0-59.
- alarm_en, input, 1, alarm armed, level.
- key_stop, input, 1, debounced one-cycle stop pulse.
- key_snooze, input, 1, debounced one-cycle snooze pulse.
- alarm_ringing, output, 1, high while in RINGING; gates the mode controller's DISPLAY exit.
- buzzer, output, 1, buzzer drive.
- snooze_active, output, 1, high while in SNOOZE.
- snooze_left, output, 2, snoozes remaining.
- state, output, 2, IDLE=00, RINGING=01, SNOOZE=10.

Function
REQ-005 Encoding 11 SHALL be unreachable; if it is entered, the next clk edge SHALL go to IDLE.
REQ-006 The match condition SHALL be: alarm_en=1, cur_hour=alm_hour, cur_min=alm_min, cur_sec=0, tick_1hz=1, all in the same cycle.
REQ-007 From IDLE, a match SHALL enter RINGING on the next edge, with sec_cnt cleared to 0 and snooze_left loaded with MAX_SNOOZE.
REQ-008 In IDLE, a match SHALL be the only transition; key_stop and key_snooze SHALL be ignored.
REQ-009 In RINGING, each tick_1hz SHALL increment sec_cnt; sec_cnt is 9 bits and SHALL saturate at 511.
REQ-010 In RINGING, when a tick_1hz makes sec_cnt equal RING_SEC, the block SHALL go to IDLE (auto-stop).
REQ-011 In RINGING, key_stop SHALL go to IDLE on the next edge.
REQ-012 In RINGING, key_snooze with snooze_left>0 SHALL go to SNOOZE, decrement snooze_left, and clear sec_cnt.
REQ-013 In RINGING, key_snooze with snooze_left=0 SHALL be treated as key_stop.
REQ-014 In SNOOZE, each tick_1hz SHALL increment sec_cnt.
REQ-015 In SNOOZE, when a tick makes sec_cnt equal SNOOZE_SEC, the block SHALL go to RINGING and clear sec_cnt; snooze_left SHALL be kept.
REQ-016 In SNOOZE, key_stop SHALL go to IDLE; key_snooze SHALL be ignored.
REQ-017 Priority within one cycle SHALL be: alarm_en=0, then key_stop, then key_snooze, then tick_1hz timeout.
REQ-018 alarm_en=0 in any state SHALL go to IDLE on the next edge.
REQ-019 When a key press and a tick_1hz occur in the same cycle, the key transition SHALL win and the tick SHALL be discarded.
REQ-020 Re-trigger rule: a match occurs only at cur_sec=0, so stopping within the alarm minute SHALL NOT re-ring until the next day.
REQ-021 Re-trigger rule: a match while in RINGING or SNOOZE SHALL be ignored.
REQ-022 alarm_ringing SHALL be (state==RINGING), and snooze_active SHALL be (state==SNOOZE); both are registered-state decodes with no input-to-output combinational path.
REQ-023 buzzer SHALL equal alarm_ringing AND NOT sec_cnt[0], giving a 1 s on / 1 s off pattern that starts on at RINGING entry.
REQ-024 Changes to alm_hour, alm_min or cur_* during RINGING or SNOOZE SHALL NOT affect the sequence.

Reset
REQ-025 rst_n=0 SHALL immediately force state=IDLE, sec_cnt=0, snooze_left=MAX_SNOOZE, alarm_ringing=0, buzzer=0, snooze_active=0, independent of clk.
REQ-026 Reset asserted mid-RINGING or mid-SNOOZE SHALL silence buzzer with no clk edge needed.
REQ-027 After rst_n rises, the first match SHALL trigger normally.

Verification
REQ-028 Scenario: alm 07:30, en=1; drive 07:29:59 then 07:30:00 with tick -> state=01, buzzer=1 the next cycle; buzzer=0 after the next tick.
REQ-029 Scenario: ringing, no keys, 60 ticks -> state=00 after the 60th tick; alarm_ringing=0.
REQ-030 Scenario: ringing, then key_snooze -> state=10, snooze_left=2; after 300 ticks -> state=01; repeat snooze three times total, then a 4th key_snooze -> state=00.
REQ-031 Scenario: key_stop, key_snooze and tick_1hz all asserted in the same cycle while RINGING -> state=00, snooze_left unchanged.
REQ-032 Scenario: key_stop at 07:30:05, time continues to 07:30:59 -> no re-trigger; alarm_en=0 during SNOOZE -> state=00 the next edge.
REQ-033 Scenario: rst_n pulsed low mid-RINGING between clk edges -> buzzer=0 and state=00 at once; snooze_left=3.
